// File: rtl/present_key_schedule.sv
// PRESENT-80 iterative key schedule.
// Produces round keys K1..K32 forward, or K32..K1 after a forward pre-run.
`timescale 1ns/1ps

module present_key_schedule #(
  parameter int NROUNDS = 32
) (
  input  logic        clk,
  input  logic        iReset_n,
  input  logic        load,
  input  logic        control,
  input  logic [79:0] key,
  input  logic        step,
  output logic [63:0] round_key,
  output logic [5:0]  round_idx,
  output logic        key_valid,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [5:0] R_LAST = 6'(NROUNDS);
  localparam logic [5:0] R_ONE  = 6'd1;

  logic [1:0]  state;
  logic [79:0] kreg;
  logic [5:0]  r;
  logic        mode;

  function automatic logic [3:0] sbox(input logic [3:0] n);
    logic [3:0] s;
    unique case (n)
      4'h0: s = 4'hC;
      4'h1: s = 4'h5;
      4'h2: s = 4'h6;
      4'h3: s = 4'hB;
      4'h4: s = 4'h9;
      4'h5: s = 4'h0;
      4'h6: s = 4'hA;
      4'h7: s = 4'hD;
      4'h8: s = 4'h3;
      4'h9: s = 4'hE;
      4'hA: s = 4'hF;
      4'hB: s = 4'h8;
      4'hC: s = 4'h4;
      4'hD: s = 4'h7;
      4'hE: s = 4'h1;
      4'hF: s = 4'h2;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] n);
    logic [3:0] s;
    unique case (n)
      4'h0: s = 4'h5;
      4'h1: s = 4'hE;
      4'h2: s = 4'hF;
      4'h3: s = 4'h8;
      4'h4: s = 4'hC;
      4'h5: s = 4'h1;
      4'h6: s = 4'h2;
      4'h7: s = 4'hD;
      4'h8: s = 4'hB;
      4'h9: s = 4'h4;
      4'hA: s = 4'h6;
      4'hB: s = 4'h3;
      4'hC: s = 4'h0;
      4'hD: s = 4'h7;
      4'hE: s = 4'h9;
      4'hF: s = 4'hA;
    endcase
    return s;
  endfunction

  // K(r) -> K(r+1)
  function automatic logic [79:0] fwd(
    input logic [79:0] k,
    input logic [5:0]  rr
  );
    logic [79:0] t;
    t = {k[18:0], k[79:19]};
    t[79:76] = sbox(t[79:76]);
    t[19:15] = t[19:15] ^ rr[4:0];
    return t;
  endfunction

  // K(r) -> K(r-1)
  function automatic logic [79:0] inv(
    input logic [79:0] k,
    input logic [5:0]  rr
  );
    logic [79:0] t;
    logic [5:0]  rm;
    rm = rr - R_ONE;
    t = k;
    t[19:15] = t[19:15] ^ rm[4:0];
    t[79:76] = sbox_inv(t[79:76]);
    return {t[60:0], t[79:61]};
  endfunction

  // Schedule sequencing: load restarts, pre-run, stepping, terminal hold
  always_ff @(posedge clk or negedge iReset_n) begin
    if (!iReset_n) begin
      state <= S_IDLE;
      kreg  <= '0;
      r     <= '0;
      mode  <= 1'b0;
    end else if (load) begin
      kreg  <= key;
      mode  <= control;
      r     <= R_ONE;
      state <= control ? S_PRE : S_RUN;
    end else begin
      case (state)
        S_PRE: begin
          kreg <= fwd(kreg, r);
          r    <= r + R_ONE;
          if (r == R_LAST - R_ONE)
            state <= S_RUN;
        end
        S_RUN: begin
          if (step) begin
            if (!mode) begin
              if (r == R_LAST) begin
                state <= S_DONE;
              end else begin
                kreg <= fwd(kreg, r);
                r    <= r + R_ONE;
              end
            end else begin
              if (r == R_ONE) begin
                state <= S_DONE;
              end else begin
                kreg <= inv(kreg, r);
                r    <= r - R_ONE;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign round_key = kreg[79:16];
  assign round_idx = r;
  assign key_valid = (state == S_RUN);
  assign busy      = (state == S_PRE);
  assign done      = (state == S_DONE);

endmodule

// File: tb/tb_present_key_schedule.sv
// Bench for present_key_schedule.
// Table-driven key model plus directed vectors.
`timescale 1ns/1ps

module tb_present_key_schedule;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b0;
  logic        control = 1'b0;
  logic        step = 1'b0;
  logic [79:0] key = '0;
  logic [63:0] round_key;
  logic [5:0]  round_idx;
  logic        key_valid;
  logic        busy;
  logic        done;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  present_key_schedule #(.NROUNDS(32)) dut (
    .clk       (clk),
    .iReset_n  (rst_n),
    .load      (load),
    .control   (control),
    .key       (key),
    .step      (step),
    .round_key (round_key),
    .round_idx (round_idx),
    .key_valid (key_valid),
    .busy      (busy),
    .done      (done)
  );

  typedef logic [79:0] tab_t [0:32];

  logic [3:0] sb_tab [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  function automatic logic [79:0] fwd_m(input logic [79:0] k, input int r);
    logic [79:0] x;
    x = (k << 61) | (k >> 19);
    x[79:76] = sb_tab[x[79:76]];
    x = x ^ (80'(r % 32) << 15);
    return x;
  endfunction

  function automatic tab_t build(input logic [79:0] k);
    tab_t t;
    t[0] = '0;
    t[1] = k;
    for (int i = 1; i < 32; i++)
      t[i+1] = fwd_m(t[i], i);
    return t;
  endfunction

  task automatic chk(input string nm, input logic [79:0] act,
                     input logic [79:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: 0 idle, 1 precompute, 2 run, 3 done; key is table[r]
  int   m_ph = 0;
  int   m_r = 0;
  logic m_dec = 1'b0;
  tab_t m_tab;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph  <= 0;
      m_r   <= 0;
      m_dec <= 1'b0;
      m_tab <= '{default: '0};
    end else if (load) begin
      m_tab <= build(key);
      m_dec <= control;
      m_r   <= 1;
      m_ph  <= control ? 1 : 2;
    end else if (m_ph == 1) begin
      m_r <= m_r + 1;
      if (m_r == 31) m_ph <= 2;
    end else if (m_ph == 2 && step) begin
      if (!m_dec) begin
        if (m_r == 32) m_ph <= 3;
        else m_r <= m_r + 1;
      end else begin
        if (m_r == 1) m_ph <= 3;
        else m_r <= m_r - 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("key_valid", 80'(key_valid), 80'(m_ph == 2));
    chk("busy", 80'(busy), 80'(m_ph == 1));
    chk("done", 80'(done), 80'(m_ph == 3));
    chk("round_idx", 80'(round_idx), 80'(m_r));
    chk("round_key", 80'(round_key), 80'(m_tab[m_r][79:16]));
  end

  task automatic drive(input logic ld, input logic st, input logic ctl,
                       input logic [79:0] k);
    load = ld;
    step = st;
    control = ctl;
    key = k;
    @(posedge clk);
    #1;
    load = 1'b0;
    step = 1'b0;
  endtask

  task automatic busy_count(input string nm);
    int n;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) n++;
    end
    chk(nm, 80'(n), 80'd31);
  endtask

  task automatic rst_mid(input string nm);
    #2;
    rst_n = 1'b0;
    #1;
    chk({nm, "_valid"}, 80'(key_valid), 80'd0);
    chk({nm, "_busy"}, 80'(busy), 80'd0);
    chk({nm, "_done"}, 80'(done), 80'd0);
    chk({nm, "_idx"}, 80'(round_idx), 80'd0);
    chk({nm, "_key"}, 80'(round_key), 80'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [79:0] ka = 80'h0123_4567_89AB_CDEF_FEDC;
  logic [79:0] kb = 80'hF00D_BEEF_1234_5A5A_C3C3;
  tab_t        zt;

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    zt = build('0);
    chk("pin_model_k2", zt[2], 80'hC000_0000_0000_0000_8000);
    chk("pin_model_k3", 80'(zt[3][79:16]), 80'h5000_1800_0000_0001);

    repeat (3) drive(1'b0, 1'b1, 1'b0, '0);

    drive(1'b1, 1'b0, 1'b0, '0);
    @(negedge clk);
    chk("zero_k1", 80'(round_key), 80'h0);
    chk("zero_k1_idx", 80'(round_idx), 80'd1);
    chk("zero_k1_valid", 80'(key_valid), 80'd1);
    drive(1'b0, 1'b1, 1'b0, '0);
    @(negedge clk);
    chk("zero_k2", 80'(round_key), 80'hC000_0000_0000_0000);
    chk("zero_k2_idx", 80'(round_idx), 80'd2);
    drive(1'b0, 1'b1, 1'b0, '0);
    @(negedge clk);
    chk("zero_k3", 80'(round_key), 80'h5000_1800_0000_0001);

    drive(1'b1, 1'b0, 1'b0, ka);
    for (int i = 0; i < 31; i++)
      drive(1'b0, 1'b1, 1'(i % 2), kb);
    @(negedge clk);
    chk("enc_last_idx", 80'(round_idx), 80'd32);
    drive(1'b0, 1'b1, 1'b0, '0);
    @(negedge clk);
    chk("enc_done", 80'(done), 80'd1);
    chk("enc_done_valid", 80'(key_valid), 80'd0);
    repeat (3) drive(1'b0, 1'b1, 1'b0, '0);

    drive(1'b1, 1'b0, 1'b1, ka);
    busy_count("dec_busy_cycles");
    chk("dec_first_idx", 80'(round_idx), 80'd32);
    for (int i = 0; i < 31; i++)
      drive(1'b0, 1'b1, 1'b1, '0);
    @(negedge clk);
    chk("dec_k1", 80'(round_key), 80'(ka[79:16]));
    chk("dec_k1_idx", 80'(round_idx), 80'd1);
    drive(1'b0, 1'b1, 1'b1, '0);
    @(negedge clk);
    chk("dec_done", 80'(done), 80'd1);
    repeat (3) drive(1'b0, 1'b1, 1'b0, '0);

    drive(1'b1, 1'b0, 1'b0, ka);
    repeat (4) drive(1'b0, 1'b1, 1'b0, '0);
    drive(1'b1, 1'b1, 1'b0, kb);
    @(negedge clk);
    chk("collide_idx", 80'(round_idx), 80'd1);
    chk("collide_key", 80'(round_key), 80'(kb[79:16]));

    drive(1'b1, 1'b0, 1'b1, kb);
    repeat (5) drive(1'b0, 1'b1, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b1, ka);
    busy_count("pre_reload_busy");
    repeat (3) drive(1'b0, 1'b1, 1'b1, '0);

    drive(1'b1, 1'b0, 1'b0, kb);
    repeat (16) drive(1'b0, 1'b1, 1'b0, '0);
    @(negedge clk);
    chk("run_r17", 80'(round_idx), 80'd17);
    rst_mid("rst_run");
    repeat (4) drive(1'b0, 1'b1, 1'b0, '0);

    drive(1'b1, 1'b0, 1'b1, ka);
    repeat (9) drive(1'b0, 1'b1, 1'b0, '0);
    chk("pre_r10", 80'(round_idx), 80'd10);
    rst_mid("rst_pre");
    repeat (4) drive(1'b0, 1'b1, 1'b1, '0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
